// File: rtl/rv32e_pkg.sv
// Shared definitions for the RV32E memory and its boot loader: lane geometry,
// one-hot boot-state encodings and a small lane-decode helper.
package rv32e_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned LANES     = 4;
  localparam int unsigned LANE_BITS = 8;
  localparam int unsigned LANE_W    = $clog2(LANES);

  typedef enum logic [3:0] {
    ST_BOOT_IDLE  = 4'b0001,
    ST_BOOT_LOAD  = 4'b0010,
    ST_BOOT_DRAIN = 4'b0100,
    ST_BOOT_RUN   = 4'b1000
  } boot_state_e;

  // One-hot lane enable for a single byte lane.
  function automatic logic [LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
    logic [LANES-1:0] oh;
    oh       = '0;
    oh[lane] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rv32e_boot_loader.sv
// Boot sequencer: accepts a byte stream into memory after reset, then releases
// the CPU. Owns the boot FSM, the byte/word write pointers and the overflow flag.
module rv32e_boot_loader
  import rv32e_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load_valid,
  input  logic [LANE_BITS-1:0]           load_data,
  input  logic                           load_last,
  output logic                           load_ready,
  output logic                           cpu_reset,
  output logic                           load_overflow,
  output logic                           boot_we,
  output logic [$clog2(DEPTH_WORDS)-1:0] boot_word,
  output logic [LANE_W-1:0]              boot_lane,
  output logic [LANE_BITS-1:0]           boot_byte
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  boot_state_e       state_q;
  logic [LANE_W-1:0] byte_ptr_q;
  logic [AW-1:0]     word_ptr_q;
  logic              accept;
  logic              last_slot;

  // load_ready is registered and high exactly in LOAD, so it doubles as the state qualifier.
  assign accept    = load_valid & load_ready;
  assign last_slot = (byte_ptr_q == LANE_W'(LANES - 1)) &&
                     (word_ptr_q == AW'(DEPTH_WORDS - 1));

  // A byte presented on a reset edge is dropped along with the rest of the transfer.
  assign boot_we   = accept & reset;
  assign boot_word = word_ptr_q;
  assign boot_lane = byte_ptr_q;
  assign boot_byte = load_data;

  // Boot FSM with pointers and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_BOOT_IDLE;
      byte_ptr_q    <= '0;
      word_ptr_q    <= '0;
      load_ready    <= 1'b0;
      cpu_reset     <= 1'b0;
      load_overflow <= 1'b0;
    end else begin
      unique case (state_q)
        ST_BOOT_IDLE: begin
          state_q    <= ST_BOOT_LOAD;
          load_ready <= 1'b1;
        end
        ST_BOOT_LOAD: begin
          if (accept) begin
            byte_ptr_q <= byte_ptr_q + 1'b1;
            if (byte_ptr_q == LANE_W'(LANES - 1)) begin
              word_ptr_q <= word_ptr_q + 1'b1;
            end
            // An explicit last byte wins over filling the final slot.
            if (load_last || last_slot) begin
              state_q    <= ST_BOOT_DRAIN;
              load_ready <= 1'b0;
              if (!load_last) begin
                load_overflow <= 1'b1;
              end
            end
          end
        end
        ST_BOOT_DRAIN: begin
          state_q   <= ST_BOOT_RUN;
          cpu_reset <= 1'b1;
        end
        ST_BOOT_RUN: begin
        end
        default: begin
          state_q    <= ST_BOOT_IDLE;
          load_ready <= 1'b0;
          cpu_reset  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rv32e_memory.sv
// Unified instruction/data memory for a small RV32E core. Two combinational
// read ports, one byte-strobed store port, and a boot loader that fills the
// array from a byte stream before releasing the CPU. Contents survive reset.
module rv32e_memory
  import rv32e_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] mem_program_addr_bus,
  output logic [XLEN-1:0] mem_program_data_bus,
  input  logic [XLEN-1:0] mem_addr_bus,
  output logic [XLEN-1:0] mem_read_data_bus,
  input  logic [XLEN-1:0] mem_write_data_bus,
  input  logic            mem_write_en,
  input  logic [LANES-1:0] mem_write_strb,
  input  logic            load_valid,
  input  logic [7:0]      load_data,
  input  logic            load_last,
  output logic            load_ready,
  output logic            cpu_reset,
  output logic            load_overflow
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [XLEN-1:0]      mem [DEPTH_WORDS];

  logic [AW-1:0]        prog_idx;
  logic [AW-1:0]        data_idx;

  logic                 boot_we;
  logic [AW-1:0]        boot_word;
  logic [LANE_W-1:0]    boot_lane;
  logic [LANE_BITS-1:0] boot_byte;

  logic                 store_en;
  logic [LANES-1:0]     wr_en;
  logic [AW-1:0]        wr_idx;
  logic [XLEN-1:0]      wr_data;

  // Bits outside the word index are don't-care: addresses alias, low bits are ignored.
  logic                 unused_addr_bits;
  assign unused_addr_bits = ^{mem_program_addr_bus[XLEN-1:AW+2], mem_program_addr_bus[1:0],
                              mem_addr_bus[XLEN-1:AW+2], mem_addr_bus[1:0]};

  assign prog_idx = mem_program_addr_bus[AW+1:2];
  assign data_idx = mem_addr_bus[AW+1:2];

  // Reads see the array before any write on the same edge.
  assign mem_program_data_bus = mem[prog_idx];
  assign mem_read_data_bus    = mem[data_idx];

  rv32e_boot_loader #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_boot_loader (
    .clk           (clk),
    .reset         (reset),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_last     (load_last),
    .load_ready    (load_ready),
    .cpu_reset     (cpu_reset),
    .load_overflow (load_overflow),
    .boot_we       (boot_we),
    .boot_word     (boot_word),
    .boot_lane     (boot_lane),
    .boot_byte     (boot_byte)
  );

  // cpu_reset is high exactly in RUN, the only state that honours stores.
  assign store_en = mem_write_en & cpu_reset & reset;

  // Merge boot and store writes into one lane-enabled write port; they never overlap.
  always_comb begin
    wr_en   = '0;
    wr_idx  = data_idx;
    wr_data = mem_write_data_bus;
    if (boot_we) begin
      wr_en   = lane_onehot(boot_lane);
      wr_idx  = boot_word;
      wr_data = {LANES{boot_byte}};
    end else if (store_en) begin
      wr_en   = mem_write_strb;
    end
  end

  // Byte-lane array write; no reset so contents persist across re-boots.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) begin
        mem[wr_idx][i*LANE_BITS +: LANE_BITS] <= wr_data[i*LANE_BITS +: LANE_BITS];
      end
    end
  end

endmodule

// File: tb/tb_rv32e_memory.sv
// Self-checking bench for rv32e_memory: a 256-word instance for boot, store,
// aliasing and re-boot, and a 16-word instance for the overflow path.
module tb_rv32e_memory;

  localparam int unsigned D0 = 256;
  localparam int unsigned D1 = 16;

  logic        clk;
  logic        reset0, reset1;

  logic [31:0] p_addr0, p_data0, d_addr0, d_rdata0, d_wdata0;
  logic        we0, lv0, ll0, lr0, cpu0, ovf0;
  logic [3:0]  strb0;
  logic [7:0]  ld0;

  logic [31:0] p_addr1, p_data1, d_addr1, d_rdata1, d_wdata1;
  logic        we1, lv1, ll1, lr1, cpu1, ovf1;
  logic [3:0]  strb1;
  logic [7:0]  ld1;

  // Byte-addressed reference images
  logic [7:0]  m0 [D0*4];
  logic [7:0]  m1 [D1*4];
  int unsigned ptr0;
  logic [7:0]  stream_q [$];

  int checks;
  int fails;

  rv32e_memory #(.DEPTH_WORDS(D0)) dut0 (
    .clk                  (clk),
    .reset                (reset0),
    .mem_program_addr_bus (p_addr0),
    .mem_program_data_bus (p_data0),
    .mem_addr_bus         (d_addr0),
    .mem_read_data_bus    (d_rdata0),
    .mem_write_data_bus   (d_wdata0),
    .mem_write_en         (we0),
    .mem_write_strb       (strb0),
    .load_valid           (lv0),
    .load_data            (ld0),
    .load_last            (ll0),
    .load_ready           (lr0),
    .cpu_reset            (cpu0),
    .load_overflow        (ovf0)
  );

  rv32e_memory #(.DEPTH_WORDS(D1)) dut1 (
    .clk                  (clk),
    .reset                (reset1),
    .mem_program_addr_bus (p_addr1),
    .mem_program_data_bus (p_data1),
    .mem_addr_bus         (d_addr1),
    .mem_read_data_bus    (d_rdata1),
    .mem_write_data_bus   (d_wdata1),
    .mem_write_en         (we1),
    .mem_write_strb       (strb1),
    .load_valid           (lv1),
    .load_data            (ld1),
    .load_last            (ll1),
    .load_ready           (lr1),
    .cpu_reset            (cpu1),
    .load_overflow        (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m0_word(input logic [31:0] a);
    int unsigned w;
    w = int'((a >> 2) % D0);
    return {m0[4*w+3], m0[4*w+2], m0[4*w+1], m0[4*w]};
  endfunction

  function automatic logic [31:0] m1_word(input logic [31:0] a);
    int unsigned w;
    w = int'((a >> 2) % D1);
    return {m1[4*w+3], m1[4*w+2], m1[4*w+1], m1[4*w]};
  endfunction

  // Random address that names word w of a depth-word memory, with junk upper/low bits.
  function automatic logic [31:0] alias_addr(input int unsigned w, input int unsigned depth);
    logic [31:0] hi;
    hi = $urandom;
    return (hi * depth * 4) | 32'(w * 4) | 32'($urandom_range(0, 3));
  endfunction

  task automatic test_reset;
    reset0 = 1'b0;
    reset1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (lr0 !== 1'b0) begin fails++; $display("FAIL reset_ready0: got %b want 0", lr0); end
    checks++; if (cpu0 !== 1'b0) begin fails++; $display("FAIL reset_cpu0: got %b want 0", cpu0); end
    checks++; if (ovf0 !== 1'b0) begin fails++; $display("FAIL reset_ovf0: got %b want 0", ovf0); end
    checks++; if (lr1 !== 1'b0) begin fails++; $display("FAIL reset_ready1: got %b want 0", lr1); end
    checks++; if (cpu1 !== 1'b0) begin fails++; $display("FAIL reset_cpu1: got %b want 0", cpu1); end
    checks++; if (ovf1 !== 1'b0) begin fails++; $display("FAIL reset_ovf1: got %b want 0", ovf1); end
    @(negedge clk);
    reset0 = 1'b1;
    reset1 = 1'b1;
    #1;
    checks++; if (lr0 !== 1'b0) begin fails++; $display("FAIL idle_ready0: got %b want 0", lr0); end
    @(posedge clk);
    #1;
    checks++; if (lr0 !== 1'b1) begin fails++; $display("FAIL load_ready0: got %b want 1", lr0); end
    checks++; if (lr1 !== 1'b1) begin fails++; $display("FAIL load_ready1: got %b want 1", lr1); end
    checks++; if (cpu0 !== 1'b0) begin fails++; $display("FAIL load_cpu0: got %b want 0", cpu0); end
    ptr0 = 0;
  endtask

  // Streams stream_q into dut0 with random gaps and random (ignored) stores.
  task automatic test_boot_stream(input bit with_last);
    int          idx;
    int          n;
    int          cyc;
    int unsigned w;
    idx = 0;
    cyc = 0;
    n   = stream_q.size();
    while (idx < n) begin
      @(negedge clk);
      lv0      = ($urandom_range(0, 3) != 0);
      ld0      = lv0 ? stream_q[idx] : 8'($urandom);
      ll0      = lv0 ? (with_last && (idx == n - 1)) : 1'($urandom);
      we0      = 1'($urandom);
      d_wdata0 = $urandom;
      strb0    = 4'($urandom);
      if (ptr0 >= 4) begin
        w       = $urandom_range(0, ptr0 / 4 - 1);
        p_addr0 = alias_addr(w, D0);
        w       = $urandom_range(0, ptr0 / 4 - 1);
        d_addr0 = alias_addr(w, D0);
      end else begin
        p_addr0 = 32'h0;
        d_addr0 = 32'h20;
      end
      #1;
      checks++;
      if (lr0 !== 1'b1) begin fails++; $display("FAIL boot_ready: got %b want 1", lr0); end
      if (ptr0 >= 4) begin
        checks++;
        if (p_data0 !== m0_word(p_addr0)) begin
          fails++; $display("FAIL boot_prog_read: got %h want %h", p_data0, m0_word(p_addr0));
        end
        checks++;
        if (d_rdata0 !== m0_word(d_addr0)) begin
          fails++; $display("FAIL boot_data_read: got %h want %h", d_rdata0, m0_word(d_addr0));
        end
      end
      @(posedge clk);
      if (lv0) begin
        m0[ptr0 % (D0*4)] = ld0;
        ptr0++;
        idx++;
      end
      cyc++;
      if (cyc > 20000) begin
        checks++; fails++;
        $display("FAIL boot_timeout: got %0d bytes want %0d", idx, n);
        break;
      end
    end
    @(negedge clk);
    lv0 = 1'b0;
    ll0 = 1'b0;
    we0 = 1'b0;
    if (with_last) begin
      #1;
      checks++; if (lr0 !== 1'b0) begin fails++; $display("FAIL drain_ready: got %b want 0", lr0); end
      checks++; if (cpu0 !== 1'b0) begin fails++; $display("FAIL drain_cpu: got %b want 0", cpu0); end
      @(posedge clk);
      #1;
      checks++; if (cpu0 !== 1'b1) begin fails++; $display("FAIL run_cpu: got %b want 1", cpu0); end
      checks++; if (lr0 !== 1'b0) begin fails++; $display("FAIL run_ready: got %b want 0", lr0); end
      checks++; if (ovf0 !== 1'b0) begin fails++; $display("FAIL run_ovf: got %b want 0", ovf0); end
    end
  endtask

  task automatic test_boot;
    logic [7:0] b;
    stream_q.delete();
    for (int i = 0; i < int'(D0 * 4); i++) begin
      b = 8'($urandom);
      if (i >= 16 && i < 20) b = 8'h00;
      stream_q.push_back(b);
    end
    stream_q[0] = 8'h13; stream_q[1] = 8'h05; stream_q[2] = 8'h50; stream_q[3] = 8'h00;
    stream_q[4] = 8'h93; stream_q[5] = 8'h05; stream_q[6] = 8'h15; stream_q[7] = 8'h00;
    test_boot_stream(1'b1);
    @(negedge clk);
    p_addr0 = 32'h0;
    d_addr0 = 32'h4;
    #1;
    checks++;
    if (p_data0 !== 32'h00500513) begin
      fails++; $display("FAIL boot_word0: got %h want 00500513", p_data0);
    end
    checks++;
    if (d_rdata0 !== 32'h00150593) begin
      fails++; $display("FAIL boot_word1: got %h want 00150593", d_rdata0);
    end
  endtask

  task automatic test_read_all;
    for (int w = 0; w < int'(D0); w++) begin
      @(negedge clk);
      p_addr0 = alias_addr(w, D0);
      d_addr0 = alias_addr($urandom_range(0, D0 - 1), D0);
      #1;
      checks++;
      if (p_data0 !== m0_word(p_addr0)) begin
        fails++; $display("FAIL read_prog %h: got %h want %h", p_addr0, p_data0, m0_word(p_addr0));
      end
      checks++;
      if (d_rdata0 !== m0_word(d_addr0)) begin
        fails++; $display("FAIL read_data %h: got %h want %h", d_addr0, d_rdata0, m0_word(d_addr0));
      end
    end
  endtask

  task automatic test_alias;
    @(negedge clk);
    d_addr0 = 32'h0000_0403;
    p_addr0 = 32'h0000_0403;
    #1;
    checks++;
    if (d_rdata0 !== 32'h00500513) begin
      fails++; $display("FAIL alias_data: got %h want 00500513", d_rdata0);
    end
    checks++;
    if (p_data0 !== 32'h00500513) begin
      fails++; $display("FAIL alias_prog: got %h want 00500513", p_data0);
    end
  endtask

  task automatic apply_store0;
    int unsigned w;
    w = int'((d_addr0 >> 2) % D0);
    for (int i = 0; i < 4; i++) begin
      if (strb0[i]) m0[4*w+i] = d_wdata0[8*i +: 8];
    end
  endtask

  task automatic test_store;
    logic [31:0] exp;
    @(negedge clk);
    we0      = 1'b1;
    d_addr0  = 32'h10;
    p_addr0  = 32'h10;
    d_wdata0 = 32'hDEADBEEF;
    strb0    = 4'b0101;
    #1;
    checks++; if (d_rdata0 !== 32'h0) begin fails++; $display("FAIL store_same_cycle: got %h want 00000000", d_rdata0); end
    @(posedge clk);
    apply_store0();
    @(negedge clk);
    we0 = 1'b0;
    #1;
    checks++;
    if (d_rdata0 !== 32'h00AD00EF) begin
      fails++; $display("FAIL store_next_cycle: got %h want 00ad00ef", d_rdata0);
    end
    checks++;
    if (p_data0 !== 32'h00AD00EF) begin
      fails++; $display("FAIL store_prog_view: got %h want 00ad00ef", p_data0);
    end
    // Random stores in RUN, with junk on the (ignored) boot inputs.
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      we0      = 1'($urandom);
      d_addr0  = $urandom;
      d_wdata0 = $urandom;
      strb0    = 4'($urandom);
      p_addr0  = ($urandom_range(0, 1) != 0) ? d_addr0 : 32'($urandom);
      lv0      = 1'($urandom);
      ld0      = 8'($urandom);
      ll0      = 1'($urandom);
      #1;
      exp = m0_word(d_addr0);
      checks++;
      if (d_rdata0 !== exp) begin
        fails++; $display("FAIL rand_store_read %h: got %h want %h", d_addr0, d_rdata0, exp);
      end
      checks++;
      if (p_data0 !== m0_word(p_addr0)) begin
        fails++; $display("FAIL rand_prog_read %h: got %h want %h", p_addr0, p_data0, m0_word(p_addr0));
      end
      checks++;
      if (lr0 !== 1'b0 || cpu0 !== 1'b1) begin
        fails++; $display("FAIL run_status: got ready=%b cpu=%b want ready=0 cpu=1", lr0, cpu0);
      end
      @(posedge clk);
      if (we0) apply_store0();
    end
    @(negedge clk);
    we0 = 1'b0;
    lv0 = 1'b0;
    ll0 = 1'b0;
  endtask

  task automatic test_overflow;
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    while (idx < int'(D1 * 4)) begin
      @(negedge clk);
      lv1      = ($urandom_range(0, 3) != 0);
      ld1      = 8'($urandom);
      ll1      = lv1 ? 1'b0 : 1'($urandom);
      we1      = 1'($urandom);
      d_addr1  = $urandom;
      d_wdata1 = $urandom;
      strb1    = 4'($urandom);
      #1;
      checks++; if (lr1 !== 1'b1) begin fails++; $display("FAIL ovf_ready: got %b want 1", lr1); end
      checks++; if (ovf1 !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b want 0", ovf1); end
      @(posedge clk);
      if (lv1) begin
        m1[idx] = ld1;
        idx++;
      end
      cyc++;
      if (cyc > 2000) begin
        checks++; fails++;
        $display("FAIL ovf_timeout: got %0d bytes want %0d", idx, D1 * 4);
        break;
      end
    end
    // Offer a 65th byte while in DRAIN
    @(negedge clk);
    lv1 = 1'b1;
    ld1 = 8'h5A;
    ll1 = 1'b0;
    we1 = 1'b0;
    #1;
    checks++; if (ovf1 !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", ovf1); end
    checks++; if (lr1 !== 1'b0) begin fails++; $display("FAIL ovf_65th_ready: got %b want 0", lr1); end
    checks++; if (cpu1 !== 1'b0) begin fails++; $display("FAIL ovf_drain_cpu: got %b want 0", cpu1); end
    @(posedge clk);
    #1;
    checks++; if (cpu1 !== 1'b1) begin fails++; $display("FAIL ovf_run_cpu: got %b want 1", cpu1); end
    checks++; if (ovf1 !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", ovf1); end
    @(negedge clk);
    lv1 = 1'b0;
    for (int w = 0; w < int'(D1); w++) begin
      @(negedge clk);
      p_addr1 = alias_addr(w, D1);
      d_addr1 = alias_addr($urandom_range(0, D1 - 1), D1);
      #1;
      checks++;
      if (p_data1 !== m1_word(p_addr1)) begin
        fails++; $display("FAIL ovf_prog %h: got %h want %h", p_addr1, p_data1, m1_word(p_addr1));
      end
      checks++;
      if (d_rdata1 !== m1_word(d_addr1)) begin
        fails++; $display("FAIL ovf_data %h: got %h want %h", d_addr1, d_rdata1, m1_word(d_addr1));
      end
    end
  endtask

  task automatic test_reboot;
    logic [31:0] old1;
    logic [7:0]  f [6];
    old1 = m0_word(32'h4);
    // Reset from RUN
    @(negedge clk);
    reset0 = 1'b0;
    lv0    = 1'b0;
    we0    = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (cpu0 !== 1'b0) begin fails++; $display("FAIL rerun_cpu: got %b want 0", cpu0); end
    checks++; if (lr0 !== 1'b0) begin fails++; $display("FAIL rerun_ready: got %b want 0", lr0); end
    @(negedge clk);
    reset0 = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (lr0 !== 1'b1) begin fails++; $display("FAIL reload_ready: got %b want 1", lr0); end
    ptr0 = 0;
    stream_q.delete();
    for (int i = 0; i < 6; i++) begin
      f[i] = 8'($urandom);
      stream_q.push_back(f[i]);
    end
    test_boot_stream(1'b0);
    // Abandon the transfer after 6 bytes
    @(negedge clk);
    reset0 = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (lr0 !== 1'b0) begin fails++; $display("FAIL abort_ready: got %b want 0", lr0); end
    @(negedge clk);
    reset0 = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (lr0 !== 1'b1) begin fails++; $display("FAIL reboot_ready: got %b want 1", lr0); end
    ptr0 = 0;
    stream_q.delete();
    stream_q.push_back(8'hAA);
    stream_q.push_back(8'hBB);
    stream_q.push_back(8'hCC);
    test_boot_stream(1'b1);
    @(negedge clk);
    p_addr0 = 32'h0;
    d_addr0 = 32'h4;
    #1;
    checks++;
    if (p_data0 !== {f[3], 8'hCC, 8'hBB, 8'hAA}) begin
      fails++; $display("FAIL reboot_word0: got %h want %h", p_data0, {f[3], 8'hCC, 8'hBB, 8'hAA});
    end
    checks++;
    if (d_rdata0 !== {old1[31:16], f[5], f[4]}) begin
      fails++; $display("FAIL reboot_word1: got %h want %h", d_rdata0, {old1[31:16], f[5], f[4]});
    end
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    ptr0     = 0;
    reset0   = 1'b0;
    reset1   = 1'b0;
    p_addr0  = '0; d_addr0 = '0; d_wdata0 = '0; we0 = 1'b0; strb0 = '0;
    lv0      = 1'b0; ld0 = '0; ll0 = 1'b0;
    p_addr1  = '0; d_addr1 = '0; d_wdata1 = '0; we1 = 1'b0; strb1 = '0;
    lv1      = 1'b0; ld1 = '0; ll1 = 1'b0;

    test_reset();
    test_boot();
    test_read_all();
    test_alias();
    test_store();
    test_overflow();
    test_reboot();
    test_read_all();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
